// File: rtl/colordet_pkg.sv
// Shared encodings for colour detection: filter ctrl codes, clr_sel bit
// positions, pixel classes and the dominant-colour FSM states.
package colordet_pkg;

  localparam logic [1:0] CTRL_RED   = 2'b01;
  localparam logic [1:0] CTRL_GREEN = 2'b00;
  localparam logic [1:0] CTRL_BLUE  = 2'b10;
  localparam logic [1:0] CTRL_NONE  = 2'b11;

  localparam int SEL_RED   = 3;
  localparam int SEL_GREEN = 2;
  localparam int SEL_BLUE  = 1;
  localparam int SEL_NONE  = 0;

  typedef enum logic [1:0] {
    CLS_NONE  = 2'd0,
    CLS_RED   = 2'd1,
    CLS_GREEN = 2'd2,
    CLS_BLUE  = 2'd3
  } pix_class_t;

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    ACCUM  = 2'd1,
    DECIDE = 2'd2
  } state_t;

endpackage

// File: rtl/pix_classify.sv
// Combinational RGB classifier: a channel wins only when it beats both other
// channels by more than MARGIN. Shared with the highlight filter.
module pix_classify
  import colordet_pkg::*;
#(
  parameter int MARGIN = 32
) (
  input  logic [7:0]  r,
  input  logic [7:0]  g,
  input  logic [7:0]  b,
  output pix_class_t  cls
);

  // 10-bit unsigned operands keep x + MARGIN from overflowing.
  logic [9:0] r_x, g_x, b_x;
  logic [9:0] r_m, g_m, b_m;

  assign r_x = {2'b00, r};
  assign g_x = {2'b00, g};
  assign b_x = {2'b00, b};
  assign r_m = r_x + 10'(MARGIN);
  assign g_m = g_x + 10'(MARGIN);
  assign b_m = b_x + 10'(MARGIN);

  always_comb begin
    cls = CLS_NONE;
    if ((r_x > g_m) && (r_x > b_m)) begin
      cls = CLS_RED;
    end else if ((g_x > r_m) && (g_x > b_m)) begin
      cls = CLS_GREEN;
    end else if ((b_x > r_m) && (b_x > g_m)) begin
      cls = CLS_BLUE;
    end
  end

endmodule

// File: rtl/dominant_color_sel.sv
// Per-frame dominant colour detector producing a one-hot clr_sel pulse at each
// frame end. Define DOMSEL_HYST_EN to suppress pulses for repeated decisions.
module dominant_color_sel
  import colordet_pkg::*;
#(
  parameter int MARGIN  = 32,
  parameter int CNT_W   = 20,
  parameter int MIN_PIX = 1024
) (
  input  logic       clk,
  input  logic       rst,
  input  logic [7:0] in_r,
  input  logic [7:0] in_g,
  input  logic [7:0] in_b,
  input  logic       pix_valid,
  input  logic       vsync,
  output logic [3:0] clr_sel,
  output logic [1:0] dom_ctrl,
  output logic       dom_valid
);

  // pix_valid qualifies one pixel per cycle with no backpressure; dom_valid is
  // a single-cycle strobe and clr_sel is non-zero only while it is high.
  state_t           state, state_nxt;
  logic             vsync_q;
  logic             frame_end;
  pix_class_t       cls;
  logic [CNT_W-1:0] cnt_r, cnt_g, cnt_b;
  logic             cnt_en;
  logic [CNT_W-1:0] win_cnt;
  logic [1:0]       dec_ctrl;
  logic [3:0]       dec_sel;
  logic             emit;

  function automatic logic [CNT_W-1:0] sat_inc(input logic [CNT_W-1:0] v);
    return (v == '1) ? v : v + CNT_W'(1);
  endfunction

  pix_classify #(.MARGIN(MARGIN)) u_classify (
    .r   (in_r),
    .g   (in_g),
    .b   (in_b),
    .cls (cls)
  );

  assign frame_end = vsync & ~vsync_q;
  assign cnt_en    = (state == ACCUM) & pix_valid & ~vsync;

  always_comb begin
    state_nxt = state;
    case (state)
      IDLE:    if (frame_end) state_nxt = ACCUM;
      ACCUM:   if (frame_end) state_nxt = DECIDE;
      DECIDE:  state_nxt = ACCUM;
      default: state_nxt = IDLE;
    endcase
  end

  // Winner selection; >= comparisons give red > green > blue on ties.
  always_comb begin
    win_cnt  = cnt_b;
    dec_ctrl = CTRL_BLUE;
    if ((cnt_r >= cnt_g) && (cnt_r >= cnt_b)) begin
      win_cnt  = cnt_r;
      dec_ctrl = CTRL_RED;
    end else if (cnt_g >= cnt_b) begin
      win_cnt  = cnt_g;
      dec_ctrl = CTRL_GREEN;
    end
    if (win_cnt < CNT_W'(MIN_PIX)) begin
      dec_ctrl = CTRL_NONE;
    end
    dec_sel = 4'b0000;
    case (dec_ctrl)
      CTRL_RED:   dec_sel[SEL_RED]   = 1'b1;
      CTRL_GREEN: dec_sel[SEL_GREEN] = 1'b1;
      CTRL_BLUE:  dec_sel[SEL_BLUE]  = 1'b1;
      default:    dec_sel[SEL_NONE]  = 1'b1;
    endcase
  end

`ifdef DOMSEL_HYST_EN
  assign emit = (state == DECIDE) && (dec_ctrl != dom_ctrl);
`else
  assign emit = (state == DECIDE);
`endif

  always_ff @(posedge clk) begin
    if (rst) begin
      state     <= IDLE;
      vsync_q   <= 1'b0;
      cnt_r     <= '0;
      cnt_g     <= '0;
      cnt_b     <= '0;
      clr_sel   <= 4'b0000;
      dom_ctrl  <= CTRL_NONE;
      dom_valid <= 1'b0;
    end else begin
      state     <= state_nxt;
      vsync_q   <= vsync;
      clr_sel   <= 4'b0000;
      dom_valid <= 1'b0;
      if ((state == IDLE && frame_end) || state == DECIDE) begin
        cnt_r <= '0;
        cnt_g <= '0;
        cnt_b <= '0;
      end else if (cnt_en) begin
        if (cls == CLS_RED)   cnt_r <= sat_inc(cnt_r);
        if (cls == CLS_GREEN) cnt_g <= sat_inc(cnt_g);
        if (cls == CLS_BLUE)  cnt_b <= sat_inc(cnt_b);
      end
      if (state == DECIDE) begin
        dom_ctrl <= dec_ctrl;
      end
      if (emit) begin
        clr_sel   <= dec_sel;
        dom_valid <= 1'b1;
      end
    end
  end

endmodule

// File: tb/tb_dominant_color_sel.sv
// Scoreboard bench for dominant_color_sel: a frame model predicts each pulse
// (with its exact cycle) and a negedge monitor checks every DUT output cycle.
module tb_dominant_color_sel;

  localparam int W = 38;  // {cycle[31:0], clr_sel[3:0], dom_ctrl[1:0]}

  logic       clk = 1'b0;
  logic       rst = 1'b1;
  logic [7:0] in_r = 8'd0, in_g = 8'd0, in_b = 8'd0;
  logic       pix_valid = 1'b0;
  logic       vsync = 1'b0;
  logic [3:0] clr_sel;
  logic [1:0] dom_ctrl;
  logic       dom_valid;

  int unsigned cyc = 0;
  int          n_checks = 0;
  int          n_pass = 0;
  logic [W-1:0] exp_q[$];

  // frame model
  bit          m_active = 1'b0;
  int          m_r = 0, m_g = 0, m_b = 0;
  logic [1:0]  m_ctrl = 2'b11;

  dominant_color_sel dut (
    .clk       (clk),
    .rst       (rst),
    .in_r      (in_r),
    .in_g      (in_g),
    .in_b      (in_b),
    .pix_valid (pix_valid),
    .vsync     (vsync),
    .clr_sel   (clr_sel),
    .dom_ctrl  (dom_ctrl),
    .dom_valid (dom_valid)
  );

  // clock / reset
  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got === exp) n_pass++;
    else $display("FAIL %s: got %0h expected %0h (cycle %0d)", tag, got, exp, cyc);
  endtask

  function automatic int classify(input int r, input int g, input int b);
    if (r > g + 32 && r > b + 32) return 1;
    if (g > r + 32 && g > b + 32) return 2;
    if (b > r + 32 && b > g + 32) return 3;
    return 0;
  endfunction

  // driver tasks
  task automatic idle_cycles(input int n);
    for (int i = 0; i < n; i++) begin
      @(negedge clk);
      pix_valid = 1'b0;
      vsync     = 1'b0;
    end
  endtask

  task automatic do_reset();
    @(negedge clk);
    rst = 1'b1;
    pix_valid = 1'b0;
    vsync = 1'b0;
    m_active = 1'b0;
    m_r = 0; m_g = 0; m_b = 0;
    m_ctrl = 2'b11;
    @(negedge clk);
    @(negedge clk);
    rst = 1'b0;
  endtask

  // n valid pixels of one colour with random invalid noise cycles in between
  task automatic send(input int n, input int r, input int g, input int b);
    int c;
    c = classify(r, g, b);
    for (int i = 0; i < n; i++) begin
      if ($urandom_range(0, 7) == 0) begin
        @(negedge clk);
        pix_valid = 1'b0;
        in_r = 8'($urandom_range(0, 255));
        in_g = 8'($urandom_range(0, 255));
        in_b = 8'($urandom_range(0, 255));
      end
      @(negedge clk);
      pix_valid = 1'b1;
      in_r = 8'(r);
      in_g = 8'(g);
      in_b = 8'(b);
      if (m_active) begin
        if (c == 1) m_r++;
        if (c == 2) m_g++;
        if (c == 3) m_b++;
      end
    end
    @(negedge clk);
    pix_valid = 1'b0;
  endtask

  // vsync rising edge; a valid red pixel rides on the edge cycle and, when a
  // decision follows, on the decide cycle too -- neither may be counted
  task automatic frame_end();
    int         win;
    logic [1:0] dec;
    logic [3:0] sel;
    bit         emit;
    bit         was_active;
    was_active = m_active;
    @(negedge clk);
    vsync = 1'b1;
    pix_valid = 1'b1;
    in_r = 8'd220; in_g = 8'd10; in_b = 8'd10;
    if (was_active) begin
      if (m_r >= m_g && m_r >= m_b) begin win = m_r; dec = 2'b01; sel = 4'b1000; end
      else if (m_g >= m_b)          begin win = m_g; dec = 2'b00; sel = 4'b0100; end
      else                          begin win = m_b; dec = 2'b10; sel = 4'b0010; end
      if (win < 1024) begin dec = 2'b11; sel = 4'b0001; end
      emit = 1'b1;
`ifdef DOMSEL_HYST_EN
      if (dec == m_ctrl) emit = 1'b0;
`endif
      if (emit) exp_q.push_back({32'(cyc + 2), sel, dec});
      m_ctrl = dec;
    end
    m_active = 1'b1;
    m_r = 0; m_g = 0; m_b = 0;
    @(negedge clk);
    vsync = 1'b0;
    pix_valid = was_active;
    @(negedge clk);
    pix_valid = 1'b0;
    idle_cycles(3);
  endtask

  // scoreboard monitor: every cycle is either the predicted pulse or quiet
  always @(negedge clk) begin
    if (!rst) begin
      if (exp_q.size() > 0 && exp_q[0][37:6] == 32'(cyc)) begin
        logic [W-1:0] e;
        e = exp_q.pop_front();
        check("pulse_valid", 32'(dom_valid), 32'd1);
        check("pulse_sel", 32'(clr_sel), 32'(e[5:2]));
        check("pulse_ctrl", 32'(dom_ctrl), 32'(e[1:0]));
      end else begin
        check("quiet", 32'({dom_valid, clr_sel}), 32'd0);
      end
    end
  end

  initial begin
    do_reset();
    @(negedge clk);
    check("rst_sel", 32'(clr_sel), 32'd0);
    check("rst_ctrl", 32'(dom_ctrl), 32'd3);
    check("rst_valid", 32'(dom_valid), 32'd0);

    send(50, 200, 40, 40);      // partial first frame, discarded
    frame_end();                // IDLE -> ACCUM, no pulse

    send(2000, 200, 40, 40);    frame_end();  // red
    check("ctrl_after_red", 32'(dom_ctrl), 32'd1);
    send(1500, 40, 200, 40);
    send(1500, 40, 40, 200);    frame_end();  // tie -> green
    check("ctrl_after_tie", 32'(dom_ctrl), 32'd0);
    send(500, 200, 40, 40);
    send(5000, 100, 100, 100);  frame_end();  // below MIN_PIX -> none
    check("ctrl_after_none", 32'(dom_ctrl), 32'd3);
    send(1100, 200, 168, 40);   frame_end();  // margin exactly 32: not red
    send(1100, 201, 168, 40);   frame_end();  // margin 33: red
    send(1023, 201, 168, 40);   frame_end();  // one short of MIN_PIX
    send(1024, 40, 40, 200);    frame_end();  // exactly MIN_PIX blue
    send(1024, 40, 40, 200);    frame_end();  // repeated blue
    send(1200, 10, 250, 0);     frame_end();  // green

    send(3000, 200, 40, 40);
    do_reset();
    @(negedge clk);
    check("rst2_sel", 32'(clr_sel), 32'd0);
    check("rst2_ctrl", 32'(dom_ctrl), 32'd3);
    check("rst2_valid", 32'(dom_valid), 32'd0);
    frame_end();                // from IDLE: no pulse
    frame_end();                // empty frame -> none

    idle_cycles(10);
    check("queue_drained", 32'(exp_q.size()), 32'd0);
    check("final_ctrl", 32'(dom_ctrl), 32'(m_ctrl));
    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
